// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the CPU return-address stack ("pila").
//   STACK_ADDR_W / STACK_DEPTH : default PC width and stack depth (also used by
//                                the PC register and next-PC mux).
//   STACK_PTR_W                : occupancy counter width, 0..DEPTH inclusive.
//   stack_op_t / decode_op     : per-edge operation decoded from push/pop and
//                                the full/empty state sampled before the edge.
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int unsigned STACK_ADDR_W = 10;
    localparam int unsigned STACK_DEPTH  = 8;
    localparam int unsigned STACK_PTR_W  = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_NOP,
        ST_PUSH,
        ST_POP,
        ST_REPL
    } stack_op_t;

    // Illegal push (full) and illegal pop (empty) decode to ST_NOP so the
    // stack itself is unchanged; push&pop on an empty stack is a plain push.
    function automatic stack_op_t decode_op(input logic push, input logic pop,
                                            input logic full, input logic empty);
        if (push && pop) begin
            return empty ? ST_PUSH : ST_REPL;
        end
        if (push) begin
            return full ? ST_NOP : ST_PUSH;
        end
        if (pop) begin
            return empty ? ST_NOP : ST_POP;
        end
        return ST_NOP;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// -----------------------------------------------------------------------------
// stack_regfile
// DEPTH x ADDR_W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
// -----------------------------------------------------------------------------
module stack_regfile #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// Hardware return-address stack for the single-cycle CPU. A call pushes the
// return PC; a return pops it, with the saved PC visible on dout in the same
// cycle so the next-PC mux can select it.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high
//   push      : store din this cycle
//   pop       : remove top entry this cycle
//   din       : return address to save
//   dout      : current top-of-stack, 0 while empty
//   count     : number of valid entries, 0..DEPTH
//   empty     : count == 0
//   full      : count == DEPTH
//   overflow  : sticky, push while full        (STACK_ERR_EN only)
//   underflow : sticky, pop while empty        (STACK_ERR_EN only)
//   err_clr   : clears sticky flags, wins over same-cycle set (STACK_ERR_EN only)
// Optional feature macro: STACK_ERR_EN
// -----------------------------------------------------------------------------
module ret_stack
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W = STACK_ADDR_W,
    parameter int unsigned DEPTH  = STACK_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [PTR_W-1:0]  count,
    output logic              empty,
`ifdef STACK_ERR_EN
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
`endif
    output logic              full
);

    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]  r_count;
    stack_op_t         w_op;
    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_waddr;
    logic [ADDR_W-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == PTR_W'(DEPTH));
    assign w_op    = decode_op(push, pop, w_full, w_empty);

    // count-1 taken modulo DEPTH: at count==DEPTH the low bits are 0 and wrap
    // to DEPTH-1. The empty case yields a junk index that dout masks off.
    assign w_top_idx = r_count[IDX_W-1:0] - IDX_W'(1);
    assign w_we      = (w_op == ST_PUSH) || (w_op == ST_REPL);
    assign w_waddr   = (w_op == ST_REPL) ? w_top_idx : r_count[IDX_W-1:0];

    stack_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (din),
        .raddr (w_top_idx),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            unique case (w_op)
                ST_PUSH: r_count <= r_count + PTR_W'(1);
                ST_POP:  r_count <= r_count - PTR_W'(1);
                ST_REPL: r_count <= r_count;
                ST_NOP:  r_count <= r_count;
            endcase
        end
    end

    assign dout  = w_empty ? '0 : w_rdata;
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

`ifdef STACK_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_ovf_set = push && !pop && w_full;
    assign w_udf_set = pop && !push && w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_ret_stack.sv
// -----------------------------------------------------------------------------
// tb_ret_stack
// Self-checking bench for ret_stack (DEPTH=8, ADDR_W=10). Flag ports and
// checks are included when STACK_ERR_EN is defined.
// -----------------------------------------------------------------------------
module tb_ret_stack;

    localparam int unsigned AW = 10;
    localparam int unsigned DP = 8;
    localparam int unsigned PW = 4;

    typedef struct packed {
        logic [PW-1:0] cnt;
        logic [AW-1:0] dout;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          udf;
    } exp_t;

    typedef struct packed {
        logic          push;
        logic          pop;
        logic [AW-1:0] din;
        exp_t          exp;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic [AW-1:0] din;
    logic [AW-1:0] dout;
    logic [PW-1:0] count;
    logic          empty;
    logic          full;
`ifdef STACK_ERR_EN
    logic          overflow;
    logic          underflow;
    logic          err_clr;
`endif

    int unsigned n_checks;
    int unsigned n_fail;
    exp_t        sb_q[$];
    vec_t        vecs[12];

    ret_stack #(
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
`ifdef STACK_ERR_EN
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr),
`endif
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int unsigned c, input int unsigned d,
                                input logic o, input logic u);
        exp_t e;
        e.cnt   = PW'(c);
        e.dout  = AW'(d);
        e.empty = (c == 0);
        e.full  = (c == DP);
        e.ovf   = o;
        e.udf   = u;
        return e;
    endfunction

    function automatic vec_t mv(input logic p, input logic q, input int unsigned d,
                                input exp_t e);
        vec_t v;
        v.push = p;
        v.pop  = q;
        v.din  = AW'(d);
        v.exp  = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 expected 1 entry", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".count"}, 32'(count), 32'(e.cnt));
        chk({tag, ".dout"},  32'(dout),  32'(e.dout));
        chk({tag, ".empty"}, 32'(empty), 32'(e.empty));
        chk({tag, ".full"},  32'(full),  32'(e.full));
`ifdef STACK_ERR_EN
        chk({tag, ".overflow"},  32'(overflow),  32'(e.ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(e.udf));
`endif
    endtask

    // Drive one operation at the falling edge, expect results after the rising edge.
    task automatic do_op(input string tag, input logic p, input logic q,
                         input logic [AW-1:0] d, input logic clr, input exp_t e);
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
`ifdef STACK_ERR_EN
        err_clr = clr;
`else
        if (clr) begin
            din = d;
        end
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs(tag);
        push = 1'b0;
        pop  = 1'b0;
`ifdef STACK_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    logic ovf_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        din      = '0;
`ifdef STACK_ERR_EN
        err_clr  = 1'b0;
        ovf_exp  = 1'b1;
`else
        ovf_exp  = 1'b0;
`endif

        // Basic push/pop, replace, and push&pop on empty.
        vecs[0]  = mv(1, 0, 'h005, mk(1, 'h005, 0, 0));
        vecs[1]  = mv(1, 0, 'h00A, mk(2, 'h00A, 0, 0));
        vecs[2]  = mv(1, 0, 'h0FF, mk(3, 'h0FF, 0, 0));
        vecs[3]  = mv(0, 1, 'h000, mk(2, 'h00A, 0, 0));
        vecs[4]  = mv(0, 1, 'h000, mk(1, 'h005, 0, 0));
        vecs[5]  = mv(1, 0, 'h020, mk(2, 'h020, 0, 0));
        vecs[6]  = mv(1, 1, 'h055, mk(2, 'h055, 0, 0));
        vecs[7]  = mv(0, 1, 'h000, mk(1, 'h005, 0, 0));
        vecs[8]  = mv(0, 1, 'h000, mk(0, 'h000, 0, 0));
        vecs[9]  = mv(0, 0, 'h1AB, mk(0, 'h000, 0, 0));
        vecs[10] = mv(1, 1, 'h123, mk(1, 'h123, 0, 0));
        vecs[11] = mv(0, 1, 'h000, mk(0, 'h000, 0, 0));

        #12;
        sb_q.push_back(mk(0, 0, 0, 0));
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].push, vecs[i].pop, vecs[i].din,
                  1'b0, vecs[i].exp);
        end

        // Fill to full, then overflow push.
        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("fill%0d", i), 1'b1, 1'b0, AW'(32'h100 + i), 1'b0,
                  mk(i + 1, 32'h100 + i, 0, 0));
        end
        do_op("ovf_push", 1'b1, 1'b0, AW'(32'h3FF), 1'b0, mk(8, 'h107, ovf_exp, 0));

        // Drain: dout must show the returning address during the pop cycle.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pop = 1'b1;
            #1;
            chk($sformatf("drain%0d.pre_dout", k), 32'(dout), 32'h107 - k);
            sb_q.push_back(mk(7 - k, (k == 7) ? 0 : (32'h106 - k), ovf_exp, 0));
            @(posedge clk);
            #1;
            check_outputs($sformatf("drain%0d", k));
            pop = 1'b0;
        end

        // Clear overflow, then underflow and clear-priority.
        do_op("clr_ovf", 1'b0, 1'b0, '0, 1'b1, mk(0, 0, 0, 0));
        do_op("udf_pop", 1'b0, 1'b1, '0, 1'b0, mk(0, 0, 0, ovf_exp));
        do_op("clr_vs_pop", 1'b0, 1'b1, '0, 1'b1, mk(0, 0, 0, 0));

        // Asynchronous reset in the middle of a cycle with count=5.
        for (int i = 0; i < 5; i++) begin
            do_op($sformatf("pre_rst%0d", i), 1'b1, 1'b0, AW'(32'h200 + i), 1'b0,
                  mk(i + 1, 32'h200 + i, 0, 0));
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb_q.push_back(mk(0, 0, 0, 0));
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        sb_q.push_back(mk(0, 0, 0, 0));
        check_outputs("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        do_op("post_rst_push", 1'b1, 1'b0, AW'(10'h0AB), 1'b0, mk(1, 'h0AB, 0, 0));
        do_op("post_rst_pop", 1'b0, 1'b1, '0, 1'b0, mk(0, 0, 0, 0));

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
